// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the register-file writeback path.
//   DATA_W / ADDR_W : default register width and register address width
//   NUM_REGS        : number of architectural registers
//   wb_req_t        : one writeback request {addr, data}
//   gnt_e           : arbitration result (none / ALU / load path)
//   wb_state_e      : output-register occupancy
package cpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_prio_arb.sv
// wb_prio_arb: writeback grant logic with ALU starvation protection.
//   CLK, RESET : clock and asynchronous active-high reset
//   alu_valid  : ALU writeback request
//   mem_valid  : load writeback request
//   space      : output register can take a write this cycle
//   grant      : combinational winner (GNT_NONE when nobody requests)
// The load path normally wins a contested cycle; after STARVE_LIMIT
// consecutive contested losses the ALU takes the next contested grant.
module wb_prio_arb
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic alu_valid,
  input  logic mem_valid,
  input  logic space,
  output gnt_e grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic             contested;

  assign contested = alu_valid & mem_valid;

  always_comb begin
    grant = GNT_NONE;
    if (contested) begin
      grant = (starve_cnt_reg == LIMIT) ? GNT_ALU : GNT_MEM;
    end else if (alu_valid) begin
      grant = GNT_ALU;
    end else if (mem_valid) begin
      grant = GNT_MEM;
    end
  end

  // Only contested cycles that actually transfer move the counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_reg <= '0;
    end else if (contested && space) begin
      if (grant == GNT_ALU) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != LIMIT) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// result path and the load path through a one-entry output register.
//   CLK, RESET            : clock, asynchronous active-high reset
//   BUSY                  : memory stall, no write retires while high
//   ALU_VALID/ADDR/DATA   : ALU writeback request, ALU_READY accepts it
//   MEM_VALID/ADDR/DATA   : load writeback request, MEM_READY accepts it
//   WRITE/INADDRESS/IN    : register file write port
//   PEND_MASK             : one-hot of the held destination while WRITE=1
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W       = cpu_pkg::DATA_W,
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BUSY,
  input  logic                 ALU_VALID,
  input  logic [ADDR_W-1:0]    ALU_ADDR,
  input  logic [DATA_W-1:0]    ALU_DATA,
  output logic                 ALU_READY,
  input  logic                 MEM_VALID,
  input  logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic [DATA_W-1:0]    MEM_DATA,
  output logic                 MEM_READY,
  output logic                 WRITE,
  output logic [ADDR_W-1:0]    INADDRESS,
  output logic [DATA_W-1:0]    IN,
  output logic [2**ADDR_W-1:0] PEND_MASK
);

  wb_state_e         state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  logic retire;
  logic space;
  logic alu_xfer;
  logic mem_xfer;
  gnt_e grant;

  assign retire = (state_reg == ST_FULL) && !BUSY;
  // RESET gates space so neither requester sees READY while reset is held.
  assign space  = !RESET && ((state_reg == ST_EMPTY) || retire);

  wb_prio_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .CLK      (CLK),
    .RESET    (RESET),
    .alu_valid(ALU_VALID),
    .mem_valid(MEM_VALID),
    .space    (space),
    .grant    (grant)
  );

  assign ALU_READY = (grant == GNT_ALU) && space;
  assign MEM_READY = (grant == GNT_MEM) && space;
  assign alu_xfer  = ALU_VALID && ALU_READY;
  assign mem_xfer  = MEM_VALID && MEM_READY;

  // A new transfer takes priority over emptying, which gives back-to-back
  // writes with no bubble when the held write retires on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_EMPTY;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (alu_xfer) begin
      state_reg <= ST_FULL;
      addr_reg  <= ALU_ADDR;
      data_reg  <= ALU_DATA;
    end else if (mem_xfer) begin
      state_reg <= ST_FULL;
      addr_reg  <= MEM_ADDR;
      data_reg  <= MEM_DATA;
    end else if (retire) begin
      state_reg <= ST_EMPTY;
    end
  end

  assign WRITE     = (state_reg == ST_FULL);
  assign INADDRESS = addr_reg;
  assign IN        = data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_mask
      assign PEND_MASK[gi] = WRITE && (addr_reg == ADDR_W'(gi));
    end
  endgenerate

endmodule
